// File: rtl/spi_reader_pkg.sv
// ============================================================================
//  Module      : spi_reader_pkg
//  Description : Shared types and constants for the SPI X-axis reader:
//                FSM state encoding, frame geometry and the default
//                command/address bytes of an ADXL362-style register read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_reader_pkg;

    // Transaction phases of one register-read frame
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int         SPI_FRAME_BITS = 32;
    localparam int         X_W            = 12;
    localparam logic [7:0] READ_CMD_DEF   = 8'h0B;
    localparam logic [7:0] X_ADDR_DEF     = 8'h0E;
    localparam logic [7:0] DUMMY_BYTE     = 8'h00;

    // Outgoing frame: command, start address, two dummy bytes clocking the data back
    function automatic logic [SPI_FRAME_BITS-1:0] build_frame(input logic [7:0] cmd,
                                                              input logic [7:0] addr);
        return {cmd, addr, DUMMY_BYTE, DUMMY_BYTE};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ============================================================================
//  Module      : spi_sclk_gen
//  Description : SPI clock generator. Counts CLK_DIV clk cycles per SCLK
//                half-period and emits one-cycle strobes on the cycle whose
//                closing edge raises or lowers SCLK. Held at sclk=0 while
//                disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sclk_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise_tick,
    output logic o_fall_tick
);

    localparam int C_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_sclk;
    logic               w_wrap;

    assign w_wrap      = i_en && (r_cnt == C_CNT_W'(CLK_DIV - 1));
    assign o_rise_tick = w_wrap && !r_sclk;
    assign o_fall_tick = w_wrap &&  r_sclk;
    assign o_sclk      = r_sclk;

    // Half-period counter; SCLK toggles at the end of every half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (!i_en) begin
            r_cnt  <= '0;
            r_sclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_x_reader.sv
// ============================================================================
//  Module      : spi_x_reader
//  Description : SPI mode-0 master that periodically reads the 12-bit signed
//                X-axis sample of an ADXL362-style accelerometer and presents
//                it as x_val with a one-cycle x_valid strobe.
//                Build option XREAD_AVG4_EN: x_val becomes the mean of the
//                last four samples, x_valid one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_x_reader
    import spi_reader_pkg::*;
#(
    parameter int         CLK_DIV     = 50,
    parameter int         POLL_PERIOD = 100_000,
    parameter logic [7:0] READ_CMD    = READ_CMD_DEF,
    parameter logic [7:0] X_ADDR      = X_ADDR_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           spi_miso,
    output logic           spi_sclk,
    output logic           spi_mosi,
    output logic           spi_cs_n,
    output logic [X_W-1:0] x_val,
    output logic           x_valid
);

    localparam int C_POLL_W  = $clog2(POLL_PERIOD);
    localparam int C_PHASE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    state_t                    r_state;
    state_t                    w_next;
    logic [C_POLL_W-1:0]       r_poll;
    logic                      r_first;
    logic [C_PHASE_W-1:0]      r_phase;
    logic [4:0]                r_bit;
    logic [SPI_FRAME_BITS-1:0] r_tx;
    logic [SPI_FRAME_BITS-1:0] r_rx;
    logic                      r_cs_n;
    logic                      r_mosi;
    logic [X_W-1:0]            r_x_val;
    logic                      r_x_valid;
    logic                      w_cs_n_nxt;
    logic                      w_start;
    logic                      w_phase_end;
    logic                      w_last_fall;
    logic                      w_rise;
    logic                      w_fall;
    logic                      w_sclk;
    logic                      w_done;
    logic [X_W-1:0]            w_sample;
    logic                      w_unused_rx;

    assign w_start     = (r_state == IDLE) && en &&
                         (r_first || (r_poll == C_POLL_W'(POLL_PERIOD - 1)));
    assign w_phase_end = (r_phase == C_PHASE_W'(CLK_DIV - 1));
    assign w_last_fall = w_fall && (r_bit == 5'd31);
    assign w_done      = (r_state == DONE);
    // Byte 3 is XDATA_L, low nibble of byte 4 is XDATA_H; its upper nibble only repeats the sign
    assign w_sample    = {r_rx[3:0], r_rx[15:8]};
    assign w_unused_rx = &{1'b0, r_rx[31:16], r_rx[7:4]};

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .i_en        (r_state == SHIFT),
        .o_sclk      (w_sclk),
        .o_rise_tick (w_rise),
        .o_fall_tick (w_fall)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start)     w_next = SETUP;
            SETUP:   if (w_phase_end) w_next = SHIFT;
            SHIFT:   if (w_last_fall) w_next = HOLD;
            HOLD:    if (w_phase_end) w_next = DONE;
            DONE:                     w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    // FSM output decode: chip select follows the state being entered so it is registered
    always_comb begin
        w_cs_n_nxt = 1'b1;
        if (w_next == SETUP || w_next == SHIFT || w_next == HOLD) w_cs_n_nxt = 1'b0;
    end

    // Poll timer, setup/hold phase timer and first-poll flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_poll  <= '0;
            r_phase <= '0;
            r_first <= 1'b1;
        end else begin
            if (!en || w_start) r_poll <= '0;
            else                r_poll <= r_poll + 1'b1;
            if ((r_state == SETUP || r_state == HOLD) && !w_phase_end) r_phase <= r_phase + 1'b1;
            else                                                       r_phase <= '0;
            if (w_start) r_first <= 1'b0;
        end
    end

    // Serial shift path: MOSI changes on SCLK falls, MISO captured on SCLK rises
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_n <= 1'b1;
            r_mosi <= 1'b0;
            r_tx   <= '0;
            r_rx   <= '0;
            r_bit  <= '0;
        end else begin
            r_cs_n <= w_cs_n_nxt;
            if (w_start) begin
                r_tx   <= build_frame(READ_CMD, X_ADDR);
                r_mosi <= READ_CMD[7];
                r_bit  <= '0;
            end else if (w_fall) begin
                r_tx   <= {r_tx[SPI_FRAME_BITS-2:0], 1'b0};
                r_mosi <= r_tx[SPI_FRAME_BITS-2];
                r_bit  <= r_bit + 1'b1;
            end
            if (w_start)     r_rx <= '0;
            else if (w_rise) r_rx <= {r_rx[SPI_FRAME_BITS-2:0], spi_miso};
        end
    end

`ifdef XREAD_AVG4_EN
    logic [X_W-1:0] r_hist [4];
    logic           r_pend;
    logic [X_W+1:0] w_sum;

    assign w_sum = {{2{r_hist[0][X_W-1]}}, r_hist[0]} + {{2{r_hist[1][X_W-1]}}, r_hist[1]} +
                   {{2{r_hist[2][X_W-1]}}, r_hist[2]} + {{2{r_hist[3][X_W-1]}}, r_hist[3]};

    // Four-sample history, then mean = sum >>> 2 (rounds toward -inf) one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_hist[i] <= '0;
            r_pend    <= 1'b0;
            r_x_val   <= '0;
            r_x_valid <= 1'b0;
        end else begin
            if (w_done) begin
                r_hist[0] <= w_sample;
                r_hist[1] <= r_hist[0];
                r_hist[2] <= r_hist[1];
                r_hist[3] <= r_hist[2];
            end
            r_pend    <= w_done;
            r_x_valid <= r_pend;
            if (r_pend) r_x_val <= w_sum[X_W+1:2];
        end
    end
`else
    // Raw sample capture at the end of each frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_val   <= '0;
            r_x_valid <= 1'b0;
        end else begin
            r_x_valid <= w_done;
            if (w_done) r_x_val <= w_sample;
        end
    end
`endif

    assign spi_sclk = w_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;
    assign x_val    = r_x_val;
    assign x_valid  = r_x_valid;

endmodule

`default_nettype wire

// File: tb/tb_spi_x_reader.sv
// ============================================================================
//  Module      : tb_spi_x_reader
//  Description : Self-checking bench for spi_x_reader with a mode-0 sensor
//                model and a behavioural reference for the reported value.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_x_reader;

    localparam int D = 4;
    localparam int P = 400;
`ifdef XREAD_AVG4_EN
    localparam int EXTRA_LAT = 1;
`else
    localparam int EXTRA_LAT = 0;
`endif
    localparam int LAT = 66 * D + 1 + EXTRA_LAT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        spi_miso = 1'b0;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic [11:0] x_val;
    logic        x_valid;

    spi_x_reader #(
        .CLK_DIV     (D),
        .POLL_PERIOD (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .spi_miso (spi_miso),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_cs_n (spi_cs_n),
        .x_val    (x_val),
        .x_valid  (x_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- sensor model (mode-0 slave) ----------------
    logic [11:0] sens_x;
    logic [11:0] bfm_x;
    logic [31:0] bfm_resp;
    logic [31:0] bfm_rx;
    int          bfm_rises = 0;
    int          phase_err = 0;
    int          stab_err  = 0;
    time         t_rise = 0, t_fall = 0, t_mosi = 0;
    logic [31:0] fr_rx;
    int          fr_rises, fr_phase, fr_stab;

    always @(negedge spi_cs_n) begin
        bfm_x     = sens_x;
        bfm_resp  = {16'h0000, sens_x[7:0], {4{sens_x[11]}}, sens_x[11:8]};
        bfm_rises = 0;
        bfm_rx    = '0;
        phase_err = 0;
        stab_err  = 0;
    end

    always @(negedge spi_cs_n or negedge spi_sclk) begin
        #1;
        if (spi_cs_n == 1'b0) spi_miso = (bfm_rises < 32) ? bfm_resp[31 - bfm_rises] : 1'b0;
    end

    always @(spi_mosi) t_mosi = $time;

    always @(posedge spi_sclk) begin
        if (spi_cs_n == 1'b0) begin
            if (bfm_rises >= 1 && ($time - t_fall) != D * 10) phase_err++;
            if (($time - t_mosi) < 10) stab_err++;
            bfm_rx = {bfm_rx[30:0], spi_mosi};
            bfm_rises++;
            t_rise = $time;
        end
    end

    always @(negedge spi_sclk) begin
        if (spi_cs_n == 1'b0) begin
            if (($time - t_rise) != D * 10) phase_err++;
            t_fall = $time;
        end
    end

    always @(posedge spi_cs_n) begin
        fr_rx    = bfm_rx;
        fr_rises = bfm_rises;
        fr_phase = phase_err;
        fr_stab  = stab_err;
    end

    // ---------------- cycle monitor ----------------
    int   cyc = 0;
    int   cs_fall_cnt = 0, last_fall_cyc = 0, prev_fall_cyc = 0;
    int   xv_cnt = 0, xv_lat = 0;
    logic [11:0] xv_val;
    logic prev_cs = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
            cs_fall_cnt++;
            prev_fall_cyc = last_fall_cyc;
            last_fall_cyc = cyc;
        end
        prev_cs = spi_cs_n;
        if (x_valid === 1'b1) begin
            xv_cnt++;
            xv_val = x_val;
            xv_lat = cyc - last_fall_cyc;
        end
    end

    // ---------------- reference model ----------------
    int hist[$];

    function automatic logic [11:0] model_next(input logic [11:0] x);
        int s;
        int sum;
        s = int'($signed(x));
`ifdef XREAD_AVG4_EN
        hist.push_back(s);
        if (hist.size() > 4) void'(hist.pop_front());
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        return 12'(sum >>> 2);
`else
        sum = s;
        return 12'(sum);
`endif
    endfunction

    task automatic wait_xv(input string tag, input int budget);
        int  start;
        bit  got;
        start = xv_cnt;
        got   = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            #1;
            if (xv_cnt != start) got = 1'b1;
        end
        check_val({tag, "_xvalid_seen"}, 32'(got), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        logic [11:0] exp;
        wait_xv(tag, P + 100 * D);
        exp = model_next(bfm_x);
        check_val({tag, "_xval"},    32'(xv_val), 32'(exp));
        check_val({tag, "_latency"}, 32'(xv_lat), 32'(LAT));
        check_val({tag, "_cmd"},     32'(fr_rx[31:24]), 32'h0B);
        check_val({tag, "_addr"},    32'(fr_rx[23:16]), 32'h0E);
        check_val({tag, "_dummy"},   32'(fr_rx[15:0]), 32'h0);
        check_val({tag, "_rises"},   32'(fr_rises), 32'd32);
        check_val({tag, "_phase"},   32'(fr_phase), 32'd0);
        check_val({tag, "_mosi_st"}, 32'(fr_stab), 32'd0);
        @(negedge clk);
        #1;
        check_val({tag, "_pulse1"},  32'(x_valid), 32'd0);
    endtask

    task automatic wait_rises(input int n);
        int c0;
        c0 = cs_fall_cnt;
        for (int i = 0; i < 4 * P && cs_fall_cnt == c0; i++) @(posedge clk);
        for (int i = 0; i < 100 * D && bfm_rises < n; i++) @(posedge clk);
        check_val("reach_bit", 32'(bfm_rises), 32'(n));
    endtask

    logic [11:0] seq [8] = '{12'd100, 12'd200, 12'd300, 12'd400,
                             12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};

    initial begin
        int xv0, cs0;
        rst    = 1'b1;
        en     = 1'b0;
        sens_x = 12'h123;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_cs_n",    32'(spi_cs_n), 32'd1);
        check_val("rst_sclk",    32'(spi_sclk), 32'd0);
        check_val("rst_mosi",    32'(spi_mosi), 32'd0);
        check_val("rst_xval",    32'(x_val),    32'd0);
        check_val("rst_xvalid",  32'(x_valid),  32'd0);

        // 1: first read right after reset
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        check_frame("t1");

        // 2: negative sample, poll period, then random samples
        sens_x = 12'hFFB;
        check_frame("t2");
        check_val("t2_period", 32'(last_fall_cyc - prev_fall_cyc), 32'(P));
        for (int k = 0; k < 3; k++) begin
            sens_x = 12'($urandom);
            check_frame("rnd");
            check_val("rnd_period", 32'(last_fall_cyc - prev_fall_cyc), 32'(P));
        end

        // 3: asynchronous reset in the middle of the frame
        sens_x = 12'($urandom);
        wait_rises(17);
        xv0 = xv_cnt;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("t3_cs_n_async", 32'(spi_cs_n), 32'd1);
        check_val("t3_sclk_async", 32'(spi_sclk), 32'd0);
        hist.delete();
        repeat (10) @(negedge clk);
        check_val("t3_no_xvalid", 32'(xv_cnt - xv0), 32'd0);
        check_val("t3_xval_rst",  32'(x_val), 32'd0);
        sens_x = seq[0];
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sens_x = seq[k];
            check_frame("t3_seq");
        end

        // 4: enable dropped mid-frame
        sens_x = 12'($urandom);
        wait_rises(10);
        @(negedge clk);
        en = 1'b0;
        xv0 = xv_cnt;
        check_frame("t4");
        check_val("t4_one_xvalid", 32'(xv_cnt - xv0), 32'd1);
        cs0 = cs_fall_cnt;
        xv0 = xv_cnt;
        repeat (3 * P) @(negedge clk);
        check_val("t4_no_cs",     32'(cs_fall_cnt - cs0), 32'd0);
        check_val("t4_no_xvalid", 32'(xv_cnt - xv0), 32'd0);
        check_val("t4_cs_idle",   32'(spi_cs_n), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
